// File: rtl/bomberman_pkg.sv
// Shared definitions for every client of the bomberman tile map.
//   tile_e       : 2-bit tile codes returned by the map arbiter
//   dir_e        : 2-bit movement / facing direction encoding
//   move_state_e : player movement controller FSM states
//   coord_t      : 5-bit tile coordinate pair, one spare bit for range checks
//   step_coord() : one-tile step of a coordinate pair in a given direction
//   pick_dir()   : fixed-priority direction select from button levels
package bomberman_pkg;

  typedef enum logic [1:0] {
    TileEmpty = 2'b00,
    TileHard  = 2'b01,
    TileSoft  = 2'b10,
    TileBomb  = 2'b11
  } tile_e;

  typedef enum logic [1:0] {
    DirUp    = 2'b00,
    DirDown  = 2'b01,
    DirLeft  = 2'b10,
    DirRight = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StUpdate
  } move_state_e;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
  } coord_t;

  // The spare top bit makes a step below zero wrap to 31, so an ordinary
  // upper-bound compare also rejects moves off the low edge of the grid.
  function automatic coord_t step_coord(input dir_e dir, input logic [3:0] x,
                                        input logic [3:0] y);
    coord_t c;
    c.x = {1'b0, x};
    c.y = {1'b0, y};
    case (dir)
      DirUp:    c.y = c.y - 5'd1;
      DirDown:  c.y = c.y + 5'd1;
      DirLeft:  c.x = c.x - 5'd1;
      default:  c.x = c.x + 5'd1;
    endcase
    return c;
  endfunction

  // btn = {up, down, left, right}; up wins over down over left over right.
  function automatic dir_e pick_dir(input logic [3:0] btn);
    dir_e d;
    if (btn[3]) begin
      d = DirUp;
    end else if (btn[2]) begin
      d = DirDown;
    end else if (btn[1]) begin
      d = DirLeft;
    end else begin
      d = DirRight;
    end
    return d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running move-rate divider.
//   clk   : system clock
//   rst_n : asynchronous active-low reset, counter returns to 0
//   tick  : one-cycle pulse while the counter sits at DIV-1, i.e. on the
//           cycle whose edge wraps it back to 0
module tick_gen #(
  parameter int unsigned DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/player_move_ctrl.sv
// Player movement controller: on each move tick, turns the held direction
// button into a one-tile move, asks the shared map arbiter what occupies the
// target tile, and only steps onto empty tiles.
//   ClkPort, Resetn          : clock, asynchronous active-low reset
//   BtnU/BtnD/BtnL/BtnR      : raw asynchronous buttons, active-high
//   tile_req, tile_x, tile_y : map read request and target coordinate
//   tile_gnt                 : one-cycle grant from the arbiter
//   tile_valid, tile_rdata   : map read return (tile_e code)
//   player_x, player_y       : current player tile
//   facing                   : last selected direction (dir_e)
//   busy                     : FSM is not idle
//   rd_err                   : sticky map read timeout flag
module player_move_ctrl
  import bomberman_pkg::*;
#(
  parameter int unsigned GRID_W     = 15,
  parameter int unsigned GRID_H     = 13,
  parameter int unsigned MOVE_DIV   = 10_000_000,
  parameter int unsigned START_X    = 1,
  parameter int unsigned START_Y    = 1,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic       ClkPort,
  input  logic       Resetn,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnL,
  input  logic       BtnR,
  output logic       tile_req,
  output logic [3:0] tile_x,
  output logic [3:0] tile_y,
  input  logic       tile_gnt,
  input  logic       tile_valid,
  input  logic [1:0] tile_rdata,
  output logic [3:0] player_x,
  output logic [3:0] player_y,
  output logic [1:0] facing,
  output logic       busy,
  output logic       rd_err
);

  localparam logic [4:0] GridWLim = 5'(GRID_W);
  localparam logic [4:0] GridHLim = 5'(GRID_H);
  localparam int unsigned WaitW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(RD_TIMEOUT - 1);

  // Button synchronizers, {up, down, left, right}.
  logic [3:0] btn_meta_q;
  logic [3:0] btn_sync_q;

  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
    end else begin
      btn_meta_q <= {BtnU, BtnD, BtnL, BtnR};
      btn_sync_q <= btn_meta_q;
    end
  end

  logic tick;

  tick_gen #(
    .DIV(MOVE_DIV)
  ) u_tick_gen (
    .clk  (ClkPort),
    .rst_n(Resetn),
    .tick (tick)
  );

  // Direction and target evaluated from the current position every cycle;
  // only consumed in IDLE on a tick.
  dir_e   sel_dir;
  coord_t tgt;
  logic   tgt_ok;
  logic   any_btn;

  always_comb begin
    any_btn = |btn_sync_q;
    sel_dir = pick_dir(btn_sync_q);
    tgt     = step_coord(sel_dir, player_x, player_y);
    tgt_ok  = (tgt.x < GridWLim) && (tgt.y < GridHLim);
  end

  move_state_e     state_q;
  logic [WaitW-1:0] wait_cnt_q;

  // tile_x/tile_y double as the latched target: they are loaded when the
  // request starts and hold until the next accepted move.
  always_ff @(posedge ClkPort or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      tile_req   <= 1'b0;
      tile_x     <= '0;
      tile_y     <= '0;
      player_x   <= 4'(START_X);
      player_y   <= 4'(START_Y);
      facing     <= DirUp;
      rd_err     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (tick && any_btn) begin
            facing <= sel_dir;
            if (tgt_ok) begin
              tile_req <= 1'b1;
              tile_x   <= tgt.x[3:0];
              tile_y   <= tgt.y[3:0];
              state_q  <= StReq;
            end
          end
        end
        StReq: begin
          if (tile_gnt) begin
            tile_req   <= 1'b0;
            wait_cnt_q <= '0;
            state_q    <= StWait;
          end
        end
        StWait: begin
          if (tile_valid) begin
            state_q <= (tile_rdata == TileEmpty) ? StUpdate : StIdle;
          end else if (wait_cnt_q == WaitLast) begin
            rd_err  <= 1'b1;
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StUpdate: begin
          player_x <= tile_x;
          player_y <= tile_y;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);

endmodule
